// File: rtl/alu_seq.sv
// Sequential ALU with one request in flight at a time. Most opcodes answer in one cycle.
// MUL (shift-add) and DIV (restoring division) iterate once per bit of WIDTH.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         ctrl,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   imm,
    input  logic [SHW:0]       shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] y,
    output logic               zero,
    output logic               carry,
    output logic               dbz,
    output logic               illegal,
    output logic [1:0]         fsm_state
);

    // Handshake: a request transfers on a rising edge where in_valid && in_ready.
    // A result transfers on a rising edge where out_valid && out_ready. in_ready is
    // high only in IDLE, so requests offered at any other time are dropped, not queued.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [SHW:0]   WIDTH_S = (SHW+1)'(WIDTH);
    localparam logic [SHW-1:0] LAST    = SHW'(WIDTH - 1);

    state_t state_q, state_d;

    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   op_b, rem, quo;
    logic               is_div;
    logic [SHW-1:0]     cnt;

    logic               long_op;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH:0]     add_w, sub_w;
    logic [2*WIDTH-1:0] fast_y;
    logic               fast_carry, fast_dbz, fast_ill;

    logic [2*WIDTH-1:0] mul_acc_nx, calc_y;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   rem_nx, quo_nx;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign fsm_state = state_q;
    assign long_op   = (ctrl == 4'd3) || ((ctrl == 4'd4) && (b != '0));

    // Single-cycle results, computed from the live inputs and registered on accept.
    always_comb begin
        fast_y     = '0;
        fast_carry = 1'b0;
        fast_dbz   = 1'b0;
        fast_ill   = 1'b0;
        opnd       = ((ctrl == 4'd9) || (ctrl == 4'd10)) ? imm : b;
        add_w      = {1'b0, a} + {1'b0, opnd};
        sub_w      = {1'b0, a} - {1'b0, opnd};
        case (ctrl)
            4'd0: fast_y[WIDTH-1:0] = a & b;
            4'd1: fast_y[WIDTH-1:0] = a | b;
            4'd2: fast_y[WIDTH-1:0] = ~a;
            4'd3: ;
            4'd4: begin
                fast_y   = {a, {WIDTH{1'b1}}};
                fast_dbz = 1'b1;
            end
            4'd5: if (shamt < WIDTH_S) fast_y[WIDTH-1:0] = a >> shamt;
            4'd6: if (shamt < WIDTH_S) fast_y[WIDTH-1:0] = a << shamt;
            4'd7, 4'd9: begin
                fast_y[WIDTH-1:0] = add_w[WIDTH-1:0];
                fast_carry        = add_w[WIDTH];
            end
            4'd8, 4'd10: begin
                fast_y[WIDTH-1:0] = sub_w[WIDTH-1:0];
                fast_carry        = sub_w[WIDTH];
            end
            default: fast_ill = 1'b1;
        endcase
    end

    // One iteration of each algorithm; the trial subtraction's top bit is the borrow.
    always_comb begin
        mul_acc_nx = acc + (op_b[0] ? mcand : '0);
        div_sh     = {rem, quo[WIDTH-1]};
        div_diff   = {1'b0, div_sh} - {2'b00, op_b};
        div_ok     = ~div_diff[WIDTH+1];
        rem_nx     = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
        quo_nx     = {quo[WIDTH-2:0], div_ok};
        calc_y     = is_div ? {rem_nx, quo_nx} : mul_acc_nx;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = long_op ? CALC : DONE;
            CALC: if (cnt == LAST) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            mcand   <= '0;
            op_b    <= '0;
            rem     <= '0;
            quo     <= '0;
            is_div  <= 1'b0;
            cnt     <= '0;
            y       <= '0;
            zero    <= 1'b0;
            carry   <= 1'b0;
            dbz     <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    if (long_op) begin
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, a};
                        op_b   <= b;
                        rem    <= '0;
                        quo    <= a;
                        is_div <= (ctrl == 4'd4);
                        cnt    <= '0;
                    end else begin
                        y       <= fast_y;
                        zero    <= (fast_y == '0);
                        carry   <= fast_carry;
                        dbz     <= fast_dbz;
                        illegal <= fast_ill;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                    end else begin
                        acc   <= mul_acc_nx;
                        mcand <= mcand << 1;
                        op_b  <= op_b >> 1;
                    end
                    // Publish on the last iteration so DONE sees a settled result.
                    if (cnt == LAST) begin
                        y       <= calc_y;
                        zero    <= (calc_y == '0);
                        carry   <= 1'b0;
                        dbz     <= 1'b0;
                        illegal <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
